// File: rtl/conv_addr_seq.sv
// Convolution address sequencer: walks the output channel, output pixel, kernel and input channel loops.
// Padding detection is compiled in only when CONV_ADDR_SEQ_PAD_EN is defined.
module conv_addr_seq #(
  parameter int DIM_IMG    = 32,
  parameter int DIM_KERNEL = 5,
  parameter int DIM_CH     = 3,
  parameter int OUT_CH     = 32,
  parameter int DIM_OUT    = 32,
  parameter int STRIDE     = 1,
  parameter int PADDING    = 2,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          addr_ready,
  output logic          busy,
  output logic          addr_valid,
  output logic [AW-1:0] s_addr,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] b_addr,
  output logic          pad,
  output logic          last,
  output logic          save_valid,
  output logic [AW-1:0] save_addr,
  output logic          done
);

  localparam int SW = (AW + 2 > 32) ? AW + 2 : 32;
  localparam int IW = (OUT_CH     > 1) ? $clog2(OUT_CH)     : 1;
  localparam int OW = (DIM_OUT    > 1) ? $clog2(DIM_OUT)    : 1;
  localparam int MW = (DIM_KERNEL > 1) ? $clog2(DIM_KERNEL) : 1;
  localparam int LW = (DIM_CH     > 1) ? $clog2(DIM_CH)     : 1;

`ifdef CONV_ADDR_SEQ_PAD_EN
  localparam int PAD_EFF = PADDING;
`else
  localparam int PAD_EFF = 0 * PADDING;
`endif

  localparam logic [IW-1:0] I_MAX = IW'(OUT_CH - 1);
  localparam logic [OW-1:0] O_MAX = OW'(DIM_OUT - 1);
  localparam logic [MW-1:0] M_MAX = MW'(DIM_KERNEL - 1);
  localparam logic [LW-1:0] L_MAX = LW'(DIM_CH - 1);

  typedef logic signed [SW-1:0] sw_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Returns {pad, s_addr}; row/col stay signed and full width until the final truncation.
  function automatic logic [AW:0] calc_src(input logic [OW-1:0] cj, input logic [OW-1:0] ck,
                                           input logic [MW-1:0] cm, input logic [MW-1:0] cn,
                                           input logic [LW-1:0] cl);
    sw_t  row, col, v;
    logic pb;
    row = sw_t'(STRIDE) * sw_t'(cj) + sw_t'(cm) - sw_t'(PAD_EFF);
    col = sw_t'(STRIDE) * sw_t'(ck) + sw_t'(cn) - sw_t'(PAD_EFF);
    v   = (row * sw_t'(DIM_IMG) + col) * sw_t'(DIM_CH) + sw_t'(cl);
`ifdef CONV_ADDR_SEQ_PAD_EN
    pb = (row < sw_t'(0)) || (row >= sw_t'(DIM_IMG)) || (col < sw_t'(0)) || (col >= sw_t'(DIM_IMG));
    if (pb) v = '0;
`else
    pb = 1'b0;
`endif
    return {pb, AW'(v)};
  endfunction

  function automatic logic [AW-1:0] calc_w(input logic [IW-1:0] ci, input logic [MW-1:0] cm,
                                           input logic [MW-1:0] cn, input logic [LW-1:0] cl);
    sw_t v;
    v = ((sw_t'(ci) * sw_t'(DIM_KERNEL) + sw_t'(cm)) * sw_t'(DIM_KERNEL) + sw_t'(cn))
        * sw_t'(DIM_CH) + sw_t'(cl);
    return AW'(v);
  endfunction

  function automatic logic [AW-1:0] calc_save(input logic [IW-1:0] ci, input logic [OW-1:0] cj,
                                              input logic [OW-1:0] ck);
    sw_t v;
    v = (sw_t'(cj) * sw_t'(DIM_OUT) + sw_t'(ck)) * sw_t'(OUT_CH) + sw_t'(ci);
    return AW'(v);
  endfunction

  state_t          state;
  logic [IW-1:0]   i, nxt_i, src_i;
  logic [OW-1:0]   j, k, nxt_j, nxt_k, src_j, src_k;
  logic [MW-1:0]   m, n, nxt_m, nxt_n, src_m, src_n;
  logic [LW-1:0]   l, nxt_l, src_l;
  logic [AW:0]     src_pad_s;
  logic [AW-1:0]   src_w;
  logic            src_last;
  logic            hs, pix_end;

  always_comb begin
    nxt_i = i; nxt_j = j; nxt_k = k; nxt_m = m; nxt_n = n; nxt_l = l;
    if (l == L_MAX) begin
      nxt_l = '0;
      if (n == M_MAX) begin
        nxt_n = '0;
        if (m == M_MAX) begin
          nxt_m = '0;
          if (k == O_MAX) begin
            nxt_k = '0;
            if (j == O_MAX) begin
              nxt_j = '0;
              nxt_i = (i == I_MAX) ? '0 : i + 1'b1;
            end else begin
              nxt_j = j + 1'b1;
            end
          end else begin
            nxt_k = k + 1'b1;
          end
        end else begin
          nxt_m = m + 1'b1;
        end
      end else begin
        nxt_n = n + 1'b1;
      end
    end else begin
      nxt_l = l + 1'b1;
    end
  end

  // The beat registered on the next edge comes from the advanced counters, or from zero when a pass starts.
  always_comb begin
    src_i = '0; src_j = '0; src_k = '0; src_m = '0; src_n = '0; src_l = '0;
    if (state == S_RUN) begin
      src_i = nxt_i; src_j = nxt_j; src_k = nxt_k;
      src_m = nxt_m; src_n = nxt_n; src_l = nxt_l;
    end
    src_pad_s = calc_src(src_j, src_k, src_m, src_n, src_l);
    src_w     = calc_w(src_i, src_m, src_n, src_l);
    src_last  = (src_i == I_MAX) && (src_j == O_MAX) && (src_k == O_MAX) &&
                (src_m == M_MAX) && (src_n == M_MAX) && (src_l == L_MAX);
    hs        = addr_valid && addr_ready;
    pix_end   = (m == M_MAX) && (n == M_MAX) && (l == L_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      {i, j, k, m, n, l} <= '0;
      busy       <= 1'b0;
      addr_valid <= 1'b0;
      s_addr     <= '0;
      w_addr     <= '0;
      b_addr     <= '0;
      pad        <= 1'b0;
      last       <= 1'b0;
      save_valid <= 1'b0;
      save_addr  <= '0;
      done       <= 1'b0;
    end else begin
      save_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_RUN;
          busy       <= 1'b1;
          addr_valid <= 1'b1;
          {i, j, k, m, n, l} <= '0;
          {pad, s_addr} <= src_pad_s;
          w_addr     <= src_w;
          b_addr     <= AW'(src_i);
          last       <= src_last;
        end
        S_RUN: if (hs) begin
          if (pix_end) begin
            save_valid <= 1'b1;
            save_addr  <= calc_save(i, j, k);
          end
          if (last) begin
            state      <= S_DONE;
            done       <= 1'b1;
            addr_valid <= 1'b0;
            {i, j, k, m, n, l} <= '0;
            {pad, s_addr} <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            last       <= 1'b0;
          end else begin
            i <= nxt_i; j <= nxt_j; k <= nxt_k;
            m <= nxt_m; n <= nxt_n; l <= nxt_l;
            {pad, s_addr} <= src_pad_s;
            w_addr     <= src_w;
            b_addr     <= AW'(src_i);
            last       <= src_last;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
